gpr_writeback: RTL and testbench

//  Writeback unit driving the general-purpose register file write port (reg_write/num_write/data_write).

---
 rtl/gpr_writeback_if.sv | 18 +
 rtl/gpr_writeback.sv | 200 ++++++++++++++++++++
 tb/tb_gpr_writeback.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_writeback_if.sv
// ----------------------------------------------------------------------------
// gpr_writeback_if
// Data-memory read bus used by the writeback unit for loads.
//   mem_req    request, held by the master until ack or abort
//   mem_addr   word-aligned read address, stable while mem_req is high
//   mem_ack    read data valid this cycle (slave -> master)
//   mem_rdata  read word, little-endian byte lanes (slave -> master)
// Modports: master = writeback unit, slave = data memory.
// ----------------------------------------------------------------------------
interface gpr_writeback_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/gpr_writeback.sv
// ----------------------------------------------------------------------------
// gpr_writeback
// Writeback unit driving the GPR file write port. Accepts one retiring
// instruction at a time: ALU results go straight to writeback, loads issue a
// data-memory read (req/ack) and sign/zero-extend the selected byte/half/word.
//
// Ports:
//   clock, reset        clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; ready only in IDLE
//   in_reg_write, in_dest, in_is_load, in_load_type, in_addr, in_alu_result
//                       retiring instruction fields
//   mem                 data-memory read bus (gpr_writeback_if.master)
//   reg_write, num_write, data_write
//                       GPR write port; strobe is one cycle, addr/data hold
//   timeout_err         one-cycle pulse when a load is aborted
//   rs, rt              decode read addresses for bypass
//   fwd_a_hit/fwd_b_hit, fwd_a/fwd_b
//                       bypass of the value being written this cycle
//
// Parameter TIMEOUT: MEM cycles without ack before abort (0 = wait forever).
// Macro WB_BYPASS_EN: enables the combinational bypass outputs; otherwise
// they are tied to 0 and rs/rt are unused.
// ----------------------------------------------------------------------------
module gpr_writeback #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_reg_write,
    input  logic [4:0]  in_dest,
    input  logic        in_is_load,
    input  logic [2:0]  in_load_type,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_alu_result,
    gpr_writeback_if.master mem,
    output logic        reg_write,
    output logic [4:0]  num_write,
    output logic [31:0] data_write,
    output logic        timeout_err,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        fwd_a_hit,
    output logic        fwd_b_hit,
    output logic [31:0] fwd_a,
    output logic [31:0] fwd_b
);

    // Counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

    state_t        state_q, state_d;
    logic [4:0]    dest_q, dest_d;
    logic          rw_q, rw_d;
    logic [2:0]    ltype_q, ltype_d;
    logic [1:0]    lane_q, lane_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [4:0]    num_q, num_d;
    logic [31:0]   data_q, data_d;
    logic          terr_q, terr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    // Lane selection and extension of the returned word.
    always_comb begin
        ld_byte = '0;
        case (lane_q)
            2'd0:    ld_byte = mem.mem_rdata[7:0];
            2'd1:    ld_byte = mem.mem_rdata[15:8];
            2'd2:    ld_byte = mem.mem_rdata[23:16];
            default: ld_byte = mem.mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (ltype_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        rw_d    = rw_q;
        ltype_d = ltype_q;
        lane_d  = lane_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        num_d   = num_q;
        data_d  = data_q;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dest_d  = in_dest;
                    rw_d    = in_reg_write;
                    ltype_d = in_load_type;
                    lane_d  = in_addr[1:0];
                    if (in_is_load) begin
                        state_d = MEM;
                        req_d   = 1'b1;
                        addr_d  = {in_addr[31:2], 2'b00};
                        cnt_d   = '0;
                    end else begin
                        // Write port is loaded on the accept edge so the
                        // strobe coincides with the single WB cycle.
                        state_d = WB;
                        wr_d    = in_reg_write && (in_dest != 5'd0);
                        num_d   = in_dest;
                        data_d  = in_alu_result;
                    end
                end
            end
            MEM: begin
                if (mem.mem_ack) begin
                    state_d = WB;
                    req_d   = 1'b0;
                    wr_d    = rw_q && (dest_q != 5'd0);
                    num_d   = dest_q;
                    data_d  = ld_data;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        terr_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            rw_q    <= 1'b0;
            ltype_q <= '0;
            lane_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            num_q   <= '0;
            data_q  <= '0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            rw_q    <= rw_d;
            ltype_q <= ltype_d;
            lane_q  <= lane_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            num_q   <= num_d;
            data_q  <= data_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign reg_write    = wr_q;
    assign num_write    = num_q;
    assign data_write   = data_q;
    assign timeout_err  = terr_q;

`ifdef WB_BYPASS_EN
    assign fwd_a_hit = wr_q && (num_q == rs) && (rs != 5'd0);
    assign fwd_b_hit = wr_q && (num_q == rt) && (rt != 5'd0);
    assign fwd_a     = data_q;
    assign fwd_b     = data_q;
`else
    logic unused_bypass;
    assign unused_bypass = ^{rs, rt};
    assign fwd_a_hit = 1'b0;
    assign fwd_b_hit = 1'b0;
    assign fwd_a     = '0;
    assign fwd_b     = '0;
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
module tb_gpr_writeback;

    localparam int unsigned TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_dest = '0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_load_type = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_alu_result = '0;
    logic        reg_write;
    logic [4:0]  num_write;
    logic [31:0] data_write;
    logic        timeout_err;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic        fwd_a_hit, fwd_b_hit;
    logic [31:0] fwd_a, fwd_b;

    gpr_writeback_if mif ();

    gpr_writeback #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_dest(in_dest),
        .in_is_load(in_is_load), .in_load_type(in_load_type),
        .in_addr(in_addr), .in_alu_result(in_alu_result),
        .mem(mif),
        .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
        .timeout_err(timeout_err),
        .rs(rs), .rt(rt),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clock = ~clock;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [4:0]  last_num  = '0;
    logic [31:0] last_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference load result from the architectural rules, using shifts and
    // two's-complement arithmetic on the whole word.
    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] w);
        int unsigned sh;
        logic [31:0] v;
        case (t)
            3'b000, 3'b100: begin
                sh = 8 * int'(a[1:0]);
                v  = (w >> sh) & 32'h0000_00FF;
                if (t == 3'b000 && v >= 32'd128) v = v - 32'd256;
            end
            3'b001, 3'b101: begin
                sh = a[1] ? 16 : 0;
                v  = (w >> sh) & 32'h0000_FFFF;
                if (t == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic check_bypass(input bit exp_wr, input logic [4:0] dest, input logic [31:0] exp_data);
        logic exp_a, exp_b;
        rs = ($urandom_range(0, 1) == 1) ? dest : 5'($urandom);
        rt = ($urandom_range(0, 1) == 1) ? dest : 5'($urandom);
        #1;
`ifdef WB_BYPASS_EN
        exp_a = exp_wr && (rs == dest) && (rs != 5'd0);
        exp_b = exp_wr && (rt == dest) && (rt != 5'd0);
        check("fwd_a_hit", fwd_a_hit, exp_a);
        check("fwd_b_hit", fwd_b_hit, exp_b);
        if (exp_a) check("fwd_a", fwd_a, exp_data);
        if (exp_b) check("fwd_b", fwd_b, exp_data);
`else
        exp_a = 1'b0;
        exp_b = 1'b0;
        check("fwd_a_hit", fwd_a_hit, exp_a);
        check("fwd_b_hit", fwd_b_hit, exp_b);
        check("fwd_a_tie", fwd_a, 32'd0 | {31'd0, exp_a});
        check("fwd_b_tie", fwd_b, 32'd0 | {31'd0, exp_b});
`endif
    endtask

    // One instruction from accept to return to IDLE. Called at a negedge in
    // IDLE. ack_at = MEM cycle (1-based) carrying ack; > TO means timeout.
    task automatic run_op(input bit is_load, input logic [2:0] lt, input logic [31:0] addr,
                          input logic [31:0] alu, input logic [4:0] dest, input bit rw,
                          input int unsigned ack_at, input logic [31:0] rdata);
        logic [31:0] exp_data;
        bit exp_wr;
        check("ready_idle", in_ready, 1'b1);
        in_valid      = 1'b1;
        in_is_load    = is_load;
        in_load_type  = lt;
        in_addr       = addr;
        in_alu_result = alu;
        in_dest       = dest;
        in_reg_write  = rw;
        @(negedge clock);
        in_valid      = 1'b0;
        in_addr       = $urandom;
        in_alu_result = $urandom;
        in_dest       = 5'($urandom);
        in_load_type  = 3'($urandom);
        exp_data      = alu;
        if (is_load) begin
            exp_data = ref_load(lt, addr, rdata);
            for (int unsigned k = 1; k <= TO; k++) begin
                check("mem_req_held", mif.mem_req, 1'b1);
                check("mem_addr", mif.mem_addr, addr & 32'hFFFF_FFFC);
                check("ready_mem", in_ready, 1'b0);
                check("no_wr_mem", reg_write, 1'b0);
                if (k == ack_at) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = rdata;
                end else begin
                    mif.mem_ack   = 1'b0;
                    mif.mem_rdata = $urandom;
                end
                @(negedge clock);
                mif.mem_ack = 1'b0;
                if (k == ack_at) break;
            end
            if (ack_at > TO) begin
                check("timeout_err", timeout_err, 1'b1);
                check("to_req_low", mif.mem_req, 1'b0);
                check("to_no_wr", reg_write, 1'b0);
                check("to_ready", in_ready, 1'b1);
                check("to_num_hold", num_write, last_num);
                @(negedge clock);
                check("to_pulse_end", timeout_err, 1'b0);
                check("to_no_wr2", reg_write, 1'b0);
                return;
            end
        end
        exp_wr = rw && (dest != 5'd0);
        check("reg_write", reg_write, exp_wr);
        check("num_write", num_write, dest);
        check("data_write", data_write, exp_data);
        check("ready_wb", in_ready, 1'b0);
        check("req_wb", mif.mem_req, 1'b0);
        check("terr_wb", timeout_err, 1'b0);
        check_bypass(exp_wr, dest, exp_data);
        last_num  = dest;
        last_data = exp_data;
        @(negedge clock);
        check("wr_one_cycle", reg_write, 1'b0);
        check("ready_after", in_ready, 1'b1);
        check("num_hold", num_write, last_num);
        check("data_hold", data_write, last_data);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [2:0] types [8];
        types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;

        #1;
        check("rst_ready", in_ready, 1'b1);
        check("rst_req", mif.mem_req, 1'b0);
        check("rst_addr", mif.mem_addr, 32'd0);
        check("rst_wr", reg_write, 1'b0);
        check("rst_num", num_write, 5'd0);
        check("rst_data", data_write, 32'd0);
        check("rst_terr", timeout_err, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases
        run_op(1'b0, 3'b000, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 0, 32'h0);
        run_op(1'b1, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 1, 32'h80FF_0011);
        run_op(1'b1, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1, 1, 32'h80FF_0011);
        run_op(1'b1, 3'b001, 32'h102, 32'h0, 5'd9, 1'b1, 3, 32'h8001_7FFF);
        run_op(1'b1, 3'b101, 32'h102, 32'h0, 5'd9, 1'b1, 3, 32'h8001_7FFF);
        run_op(1'b0, 3'b000, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1, 0, 32'h0);
        run_op(1'b1, 3'b010, 32'h203, 32'h0, 5'd3, 1'b1, TO + 1, 32'h1234_5678);
        run_op(1'b1, 3'b010, 32'h207, 32'h0, 5'd4, 1'b1, TO, 32'hCAFE_F00D);
        run_op(1'b0, 3'b000, 32'h0, 32'h5555_AAAA, 5'd6, 1'b0, 0, 32'h0);

        // Ack outside MEM is ignored
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        mif.mem_ack = 1'b0;
        check("idle_ack_wr", reg_write, 1'b0);
        check("idle_ack_ready", in_ready, 1'b1);
        check("idle_ack_data", data_write, last_data);

        // Reset while waiting in MEM
        in_valid = 1'b1; in_is_load = 1'b1; in_dest = 5'd12; in_reg_write = 1'b1;
        in_addr = 32'h300; in_load_type = 3'b010;
        @(negedge clock);
        in_valid = 1'b0;
        check("pre_rst_req", mif.mem_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_req", mif.mem_req, 1'b0);
        check("async_rst_ready", in_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'h0BAD_0BAD;
        last_num = '0;
        last_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            mif.mem_ack = 1'b0;
            check("post_rst_wr", reg_write, 1'b0);
            check("post_rst_ready", in_ready, 1'b1);
        end
        check("post_rst_num", num_write, 5'd0);
        check("post_rst_data", data_write, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            bit          is_load;
            int unsigned ack_at;
            logic [31:0] a;
            is_load = ($urandom_range(0, 2) != 0);
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       ack_at = TO;
                1:       ack_at = TO + 1;
                default: ack_at = $urandom_range(1, 5);
            endcase
            run_op(is_load, types[$urandom_range(0, 7)], a, $urandom, 5'($urandom),
                   ($urandom_range(0, 4) != 0), ack_at, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
